// File: rtl/bit_permute_pipe.sv
// Two-stage valid/ready pipeline that reorders the bits of an operand:
// pass, full bit reverse, byte swap or per-byte bit reverse, with a tag carried alongside.
module bit_permute_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NB = WIDTH / 8;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_REV   = 2'b01;
    localparam logic [1:0] MODE_BSWAP = 2'b10;
    localparam logic [1:0] MODE_BREV8 = 2'b11;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_data_reg;
    logic [1:0]       s1_mode_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_data_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;

    logic [WIDTH-1:0] rev_data;
    logic [WIDTH-1:0] bswap_data;
    logic [WIDTH-1:0] brev8_data;
    logic [WIDTH-1:0] perm_next;

    // Handshake: S2 frees when empty or being popped; in_ready thus follows out_ready combinationally.
    assign s2_free  = !s2_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_free;
    assign in_ready = !s1_valid_reg || s1_adv;
    assign accept   = in_valid && in_ready;

    // Permutations are pure wiring from the S1 operand register.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign rev_data[gi] = s1_data_reg[WIDTH-1-gi];
        end

        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign bswap_data[8*gi +: 8] = s1_data_reg[8*(NB-1-gi) +: 8];
            for (genvar gj = 0; gj < 8; gj++) begin : g_bit
                assign brev8_data[8*gi+gj] = s1_data_reg[8*gi+7-gj];
            end
        end
    endgenerate

    always_comb begin
        perm_next = s1_data_reg;
        case (s1_mode_reg)
            MODE_PASS:  perm_next = s1_data_reg;
            MODE_REV:   perm_next = rev_data;
            MODE_BSWAP: perm_next = bswap_data;
            MODE_BREV8: perm_next = brev8_data;
            default:    perm_next = s1_data_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_mode_reg  <= '0;
            s1_tag_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_tag_reg   <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= in_data;
                s1_mode_reg  <= in_mode;
                s1_tag_reg   <= in_tag;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end

            // S2 data/tag only change on a load, so they hold while stalled.
            if (s1_adv) begin
                s2_valid_reg <= 1'b1;
                s2_data_reg  <= perm_next;
                s2_tag_reg   <= s1_tag_reg;
            end else if (out_ready) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_tag   = s2_tag_reg;

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Directed bench for bit_permute_pipe: 32-bit instance for modes, latency, back-pressure,
// streaming and reset; small 16-bit and 8-bit instances for width-specific vectors.
module tb_bit_permute_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    logic        v16 = 1'b0, r16, ov16, or16 = 1'b1;
    logic [15:0] d16 = '0, od16;
    logic [1:0]  m16 = '0;
    logic [1:0]  t16 = '0, ot16;

    logic        v8 = 1'b0, r8, ov8, or8 = 1'b1;
    logic [7:0]  d8 = '0, od8;
    logic [1:0]  m8 = '0;
    logic [3:0]  t8 = '0, ot8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_permute_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    bit_permute_pipe #(.WIDTH(16), .TAG_W(2)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(v16), .in_ready(r16), .in_data(d16),
        .in_mode(m16), .in_tag(t16),
        .out_valid(ov16), .out_ready(or16),
        .out_data(od16), .out_tag(ot16)
    );

    bit_permute_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(r8), .in_data(d8),
        .in_mode(m8), .in_tag(t8),
        .out_valid(ov8), .out_ready(or8),
        .out_data(od8), .out_tag(ot8)
    );

    // Reference model for the 32-bit instance.
    function automatic logic [31:0] perm32(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        r = d;
        case (m)
            2'b01: for (int i = 0; i < 32; i++) r[i] = d[31-i];
            2'b10: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
            2'b11: for (int b = 0; b < 4; b++)
                       for (int j = 0; j < 8; j++) r[8*b+j] = d[8*b+7-j];
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
        checks++;
        if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        $display("reset: out_valid=%b out_data=%h in_ready=%b", out_valid, out_data, in_ready);
        step();
    endtask

    task automatic test_modes();
        logic [31:0] vin[6]  = '{32'h00000001, 32'hF0000000, 32'h12345678,
                                 32'h01020380, 32'hDEADBEEF, 32'h0000A5C3};
        logic [1:0]  vmd[6]  = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
        logic [31:0] vexp[6] = '{32'h80000000, 32'h0000000F, 32'h78563412,
                                 32'h8040C001, 32'hDEADBEEF, 32'h0000A5C3};
        logic [3:0]  vtg[6]  = '{4'd3, 4'd5, 4'd9, 4'd12, 4'd1, 4'd7};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = vin[k]; in_mode = vmd[k]; in_tag = vtg[k];
            step();
            in_valid = 1'b0; in_data = 32'h5555AAAA; in_mode = 2'b00;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_early_valid got=%b exp=0", k, out_valid); end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== vexp[k] || out_tag !== vtg[k]) begin
                errors++;
                $display("FAIL mode%0d_result got v=%b d=%h t=%h exp v=1 d=%h t=%h",
                         k, out_valid, out_data, out_tag, vexp[k], vtg[k]);
            end
            $display("mode=%b in=%h out=%h tag=%h", vmd[k], vin[k], out_data, out_tag);
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'h000000A1, b = 32'h0000B200, c = 32'h00C30000;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a; in_mode = 2'b01; in_tag = 4'hA;
        step();
        in_data = b; in_mode = 2'b10; in_tag = 4'hB;
        step();
        in_data = c; in_mode = 2'b11; in_tag = 4'hC;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== perm32(a, 2'b01) || out_tag !== 4'hA) begin
            errors++;
            $display("FAIL bp_hold_A got v=%b d=%h t=%h exp v=1 d=%h t=a", out_valid, out_data, out_tag, perm32(a, 2'b01));
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        $display("backpressure: held out=%h, releasing", out_data);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== perm32(b, 2'b10) || out_tag !== 4'hB) begin
            errors++;
            $display("FAIL bp_out_B got v=%b d=%h t=%h exp v=1 d=%h t=b", out_valid, out_data, out_tag, perm32(b, 2'b10));
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== perm32(c, 2'b11) || out_tag !== 4'hC) begin
            errors++;
            $display("FAIL bp_out_C got v=%b d=%h t=%h exp v=1 d=%h t=c", out_valid, out_data, out_tag, perm32(c, 2'b11));
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_q[$];
        logic [3:0]  tag_q[$];
        logic [31:0] e;
        logic [3:0]  et;
        int n_out = 0, first = -1, last = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                in_mode  = 2'($urandom_range(0, 3));
                in_tag   = 4'($urandom_range(0, 15));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(perm32(in_data, in_mode));
                tag_q.push_back(in_tag);
            end
            step();
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got d=%h exp=no_item", out_data);
                end else begin
                    e = exp_q.pop_front();
                    et = tag_q.pop_front();
                    if (out_data !== e || out_tag !== et) begin
                        errors++;
                        $display("FAIL stream_item%0d got d=%h t=%h exp d=%h t=%h", n_out, out_data, out_tag, e, et);
                    end
                    $display("stream: out=%h tag=%h", out_data, out_tag);
                end
                n_out++;
                if (first < 0) first = c;
                last = c;
            end
        end
        checks++;
        if (n_out != 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", n_out); end
        checks++;
        if (last - first != 15) begin errors++; $display("FAIL stream_rate got span=%0d exp=15", last - first); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11111111; in_mode = 2'b00; in_tag = 4'h6;
        step();
        in_data = 32'h22222222; in_tag = 4'h7;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state got v=%b d=%h rdy=%b exp v=0 d=00000000 rdy=1", out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_ghost got=%0d exp=0", seen); end
        $display("reset midflight: ghost outputs=%0d", seen);
    endtask

    task automatic test_widths();
        logic [15:0] a16[2] = '{16'h0001, 16'h1234};
        logic [1:0]  m16v[2] = '{2'b01, 2'b10};
        logic [15:0] e16[2] = '{16'h8000, 16'h3412};
        logic [7:0]  a8[3] = '{8'hA5, 8'h01, 8'h01};
        logic [1:0]  m8v[3] = '{2'b10, 2'b11, 2'b01};
        logic [7:0]  e8[3] = '{8'hA5, 8'h80, 8'h80};
        for (int k = 0; k < 2; k++) begin
            v16 = 1'b1; d16 = a16[k]; m16 = m16v[k]; t16 = 2'(k + 1);
            step();
            v16 = 1'b0;
            step();
            checks++;
            if (ov16 !== 1'b1 || od16 !== e16[k] || ot16 !== 2'(k + 1)) begin
                errors++;
                $display("FAIL w16_vec%0d got v=%b d=%h t=%h exp v=1 d=%h t=%h", k, ov16, od16, ot16, e16[k], 2'(k + 1));
            end
            $display("w16: mode=%b in=%h out=%h", m16v[k], a16[k], od16);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            v8 = 1'b1; d8 = a8[k]; m8 = m8v[k]; t8 = 4'(k + 9);
            step();
            v8 = 1'b0;
            step();
            checks++;
            if (ov8 !== 1'b1 || od8 !== e8[k] || ot8 !== 4'(k + 9)) begin
                errors++;
                $display("FAIL w8_vec%0d got v=%b d=%h t=%h exp v=1 d=%h t=%h", k, ov8, od8, ot8, e8[k], 4'(k + 9));
            end
            $display("w8: mode=%b in=%h out=%h", m8v[k], a8[k], od8);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_stream();
        test_reset_midflight();
        test_widths();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bit_permute_pipe.md
# bit_permute_pipe

Parametrised, two-stage pipelined bit-permutation unit: the successor to the fixed 32-bit bit reverser. It adds selectable data width, four permutation modes (pass, full bit reverse, byte swap, per-byte bit reverse), a valid/ready handshake with full back-pressure, and a pass-through tag. It sits in the FP32/integer datapath wherever a shifter, count-leading-zeros front end or RISC-V rev8/brev8 operation needs a reordered operand.

## Interface
- WIDTH, 32: data width in bits; legal values 8, 16, 32, 64 (multiple of 8 required for byte modes).
- TAG_W, 4: width of the opaque tag carried alongside each item; minimum 1.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has an item on in_data/in_mode/in_tag.
- in_ready  out  1  unit accepts an item this cycle.
- in_data  in  WIDTH  operand.
- in_mode  in  2  00 pass, 01 bit reverse, 10 byte swap, 11 per-byte bit reverse.
- in_tag  in  TAG_W  user tag, returned unchanged.
- out_valid  out  1  result on out_data/out_tag is valid.
- out_ready  in  1  consumer takes the result this cycle.
- out_data  out  WIDTH  permuted result.
- out_tag  out  TAG_W  tag of the item on out_data.

## Operation
- Mode 00: out = in.
- Mode 01: out[i] = in[WIDTH-1-i] for all i.
- Mode 10: byte k of out = byte (WIDTH/8-1-k) of in. For WIDTH=8 this equals pass.
- Mode 11: within each byte, bit j = in bit (7-j) of the same byte. Byte order is preserved.
- Stage 1 (S1) registers in_data, in_mode, in_tag and s1_valid on acceptance. The permutation is combinational from the S1 registers.
- Stage 2 (S2) registers the permuted data, the tag and s2_valid. out_data, out_tag and out_valid come directly from the S2 registers.
- Transfer rules:
  - s2_free = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !s1_valid | s1_adv.
- Input accept = in_valid & in_ready. On accept, S1 loads and s1_valid = 1. Otherwise, if s1_adv, s1_valid = 0.
- If s1_adv, S2 loads and s2_valid = 1. Else if out_ready, s2_valid = 0.
- A simultaneous accept, S1 to S2 move and output pop in the same cycle is legal and gives full throughput.
- in_ready depends combinationally on out_ready. No combinational path runs from in_valid to out_valid or from in_data to out_data.
- While out_valid = 1 and out_ready = 0, out_data and out_tag hold stable.
- The producer may change in_data or in_mode while in_valid = 0 or in_ready = 0. Only the values present at the accepting edge are used.

## Timing
- Reset (rst high at a rising edge):
  - s1_valid = 0 and s2_valid = 0.
  - out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 during the first cycle after reset is released.
- Reset mid-operation discards all in-flight items with no output. rst has priority over every accept and transfer in the same cycle.
- Latency: an item accepted at edge k is in S1 after k and in S2 after k+1, so out_valid is high in the cycle after edge k+1 (2 cycles), given out_ready was high or S2 was empty.
- Throughput: 1 item per cycle with out_ready held high.
- Capacity: 2 items. With out_ready = 0, the unit accepts 2 items, then in_ready = 0 until out_ready rises. In the cycle out_ready rises, in_ready = 1 again.
- No item is lost or duplicated under any valid/ready pattern. Order is strictly preserved.

## Test plan
- WIDTH=32, mode 01, in_data 0x00000001, tag 3, out_ready=1 -> out_valid exactly 2 cycles after accept; out_data 0x80000000, out_tag 3. In a second test, in_data 0xF0000000 -> 0x0000000F.
- WIDTH=32, mode 10, in_data 0x12345678 -> 0x78563412. Mode 11, in_data 0x01020380 -> 0x8040C001. Mode 00, in_data 0xDEADBEEF -> 0xDEADBEEF.
- Back-pressure: out_ready=0, offer 3 back-to-back items A,B,C -> A and B accepted, in_ready=0 while C is offered, out_data stays at A. Raise out_ready -> A, B, C emerge in order, one per cycle, C accepted in the cycle out_ready rises.
- Streaming: 16 consecutive items with random modes and tags, out_ready=1 -> one result per cycle, order preserved, each result matches the reference model.
- Reset mid-flight: 2 items in the pipe, assert rst for 1 cycle -> out_valid=0, out_data=0, in_ready=1 next cycle; neither item ever appears.
- WIDTH=16 and WIDTH=8 builds: mode 01 on 0x0001 -> 0x8000, mode 10 on 0x1234 -> 0x3412. WIDTH=8, mode 10 on 0xA5 -> 0xA5, mode 11 on 0x01 -> 0x80.
